// File: rtl/spell_wb_host.sv
// spell_wb_host: Wishbone classic-cycle initiator for the spell register slave.
// Accepts single commands on a valid/ready port (READ, WRITE, RUN_WAIT) and
// turns them into one bus transfer at a time. RUN_WAIT writes REG_RUN, then
// polls it every POLL_INTERVAL cycles until bit0 reads back 0.
// Ports:
//   clock, reset        : clock and synchronous active-low reset
//   cmd_valid/ready     : command handshake; cmd_op, cmd_addr, cmd_data payload
//   rsp_valid/ready     : response handshake; rsp_data, rsp_error payload
//   o_wb_*, i_wb_*      : Wishbone classic initiator signals
module spell_wb_host #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data
);

    localparam int unsigned PW = 16;
    localparam int unsigned TW = 8;
    localparam logic [23:0]   RUN_OFFSET = 24'h00c;
    localparam logic [PW-1:0] POLL_LOAD  = PW'(POLL_INTERVAL);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, POLL, RESP} state_t;

    state_t        state_q, state_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          run_q, run_d;          // command is a RUN_WAIT
    logic          rd_phase_q, rd_phase_d; // RUN_WAIT is in its polling phase
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_error_q, rsp_error_d;

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            run_q       <= 1'b0;
            rd_phase_q  <= 1'b0;
            timer_q     <= '0;
            poll_q      <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            run_q       <= run_d;
            rd_phase_q  <= rd_phase_d;
            timer_q     <= timer_d;
            poll_q      <= poll_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        run_d       = run_q;
        rd_phase_d  = rd_phase_q;
        timer_d     = timer_q;
        poll_d      = poll_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    wdata_d    = cmd_data;
                    addr_d     = BASE_ADDR | {8'h00, cmd_addr};
                    run_d      = 1'b0;
                    rd_phase_d = 1'b0;
                    timer_d    = '0;
                    unique case (cmd_op)
                        2'd0, 2'd1: begin
                            we_d    = cmd_op[0];
                            stb_d   = 1'b1;
                            state_d = REQ;
                        end
                        2'd2: begin
                            we_d    = 1'b1;
                            addr_d  = BASE_ADDR | {8'h00, RUN_OFFSET};
                            run_d   = 1'b1;
                            stb_d   = 1'b1;
                            state_d = REQ;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_error_d = 1'b1;
                            rsp_data_d  = '0;
                            state_d     = RESP;
                        end
                    endcase
                end
            end
            REQ: begin
                if (i_wb_ack) begin
                    stb_d = 1'b0;
                    if (!run_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b0;
                        rsp_data_d  = we_q ? 32'h0 : i_wb_data;
                        state_d     = RESP;
                    end else if (!rd_phase_q || i_wb_data[0]) begin
                        // core still running (or just started): poll again later
                        poll_d  = POLL_LOAD;
                        state_d = POLL;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b0;
                        rsp_data_d  = i_wb_data;
                        state_d     = RESP;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            POLL: begin
                if (poll_q <= PW'(1)) begin
                    we_d       = 1'b0;
                    addr_d     = BASE_ADDR | {8'h00, RUN_OFFSET};
                    rd_phase_d = 1'b1;
                    timer_d    = '0;
                    stb_d      = 1'b1;
                    state_d    = REQ;
                end else begin
                    poll_d = poll_q - PW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;
    assign o_wb_cyc  = stb_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = we_q;
    assign o_wb_addr = addr_q;
    assign o_wb_data = wdata_q;

endmodule

// File: tb/tb_spell_wb_host.sv
// tb_spell_wb_host: self-checking bench for spell_wb_host.
// Contains a behavioural spell slave (registered, repeating ack; scratch
// registers, stack push at 0x018, SP at 0x004, REG_RUN at 0x00c that sleeps
// 100 cycles after being started), a passive bus monitor, and a command-level
// reference model (register shadow, push count) used to predict responses.
module tb_spell_wb_host;

    localparam int unsigned TB_POLL    = 16;
    localparam int unsigned TB_TIMEOUT = 8;
    localparam logic [31:0] BASE       = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    spell_wb_host #(.BASE_ADDR(BASE), .POLL_INTERVAL(TB_POLL), .TIMEOUT(TB_TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
    );

    always #5 clock = ~clock;

    // Spell slave model
    logic        noack  = 1'b0;
    logic        inject = 1'b0;
    logic        sl_ack = 1'b0;
    logic        sl_prev = 1'b0;
    logic [31:0] sl_rdata = 32'h0;
    logic [31:0] sl_mem [64];
    int          sl_push = 0;
    int          sl_run  = 0;

    always @(posedge clock) begin
        sl_prev <= o_wb_stb;
        sl_ack  <= o_wb_stb && !noack;
        if (sl_run > 0) sl_run <= sl_run - 1;
        if (o_wb_stb && !noack) begin
            case (o_wb_addr[7:0])
                8'h04:   sl_rdata <= 32'(sl_push);
                8'h0c:   sl_rdata <= {31'h0, (sl_run > 0)};
                default: sl_rdata <= sl_mem[o_wb_addr[7:2]];
            endcase
            if (o_wb_we && !sl_prev) begin
                case (o_wb_addr[7:0])
                    8'h18:   sl_push <= sl_push + 1;
                    8'h0c:   if (o_wb_data[0]) sl_run <= 100;
                    default: sl_mem[o_wb_addr[7:2]] <= o_wb_data;
                endcase
            end
        end
    end

    assign i_wb_ack  = sl_ack | inject;
    assign i_wb_data = sl_rdata;

    // Bus monitor: transfer log, stb low gaps, stb high burst lengths
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       xfer_q [$];
    int          gap_q [$];
    logic        mon_prev = 1'b0;
    logic        mon_first = 1'b0;
    int          low_run = 0;
    int          high_run = 0;
    int          last_high = 0;
    int          cyc_bad = 0;
    int          unstable_bad = 0;
    xfer_t       cur;

    always @(negedge clock) begin
        if (o_wb_cyc !== o_wb_stb) cyc_bad = cyc_bad + 1;
        if (o_wb_stb === 1'b1) begin
            if (!mon_prev) begin
                cur = '{we: o_wb_we, addr: o_wb_addr, data: o_wb_data};
                xfer_q.push_back(cur);
                if (mon_first) gap_q.push_back(low_run);
                mon_first = 1'b1;
                low_run  = 0;
                high_run = 0;
            end else if (cur.we !== o_wb_we || cur.addr !== o_wb_addr || cur.data !== o_wb_data) begin
                unstable_bad = unstable_bad + 1;
            end
            high_run = high_run + 1;
            mon_prev = 1'b1;
        end else begin
            if (mon_prev) last_high = high_run;
            low_run  = low_run + 1;
            mon_prev = 1'b0;
        end
    end

    // Reference model state
    int          asserts = 0;
    int          failures = 0;
    logic        rdy_tie = 1'b0;
    logic [31:0] shadow [64];
    int          exp_push = 0;

    task automatic send_cmd(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        while (cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        asserts++;
        if (n >= 1000) begin
            failures++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int delay, output logic [31:0] d, output logic e, output int lat);
        int n = 0;
        d = '0; e = 1'b0;
        while (n < 3000) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) break;
            n++;
        end
        lat = n;
        asserts++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
        end else begin
            d = rsp_data; e = rsp_error;
            repeat (delay) @(negedge clock);
            rsp_ready = 1'b1;
            @(posedge clock);
            #1 rsp_ready = rdy_tie;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 24'h0; cmd_data = 32'hdead_beef;
        rsp_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            asserts++;
            if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, cmd_ready,
                 rsp_valid, rsp_data, rsp_error} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: stb=%b cmd_ready=%b rsp_valid=%b addr=%h, required all 0",
                         o_wb_stb, cmd_ready, rsp_valid, o_wb_addr);
            end
        end
        reset = 1'b1; cmd_valid = 1'b0;
        @(negedge clock);
        asserts++;
        if (cmd_ready !== 1'b1 || o_wb_stb !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: cmd_ready=%b stb=%b, required 1/0", cmd_ready, o_wb_stb);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic e; int lat; int x0;
        x0 = xfer_q.size();
        send_cmd(2'd1, 24'h000, 32'h42);
        get_rsp(0, d, e, lat);
        shadow[0] = 32'h42;
        asserts++;
        if (d !== 32'h0 || e !== 1'b0 || lat != 2) begin
            failures++;
            $display("FAIL write_rsp: data=%h err=%b lat=%0d, required 0/0/2", d, e, lat);
        end
        asserts++;
        if (xfer_q.size() != x0 + 1 || xfer_q[x0] !== '{we: 1'b1, addr: BASE, data: 32'h42}) begin
            failures++;
            $display("FAIL write_bus: count=%0d xfer=%h, required 1 write of 42 to %h",
                     xfer_q.size() - x0, xfer_q[x0], BASE);
        end
        x0 = xfer_q.size();
        send_cmd(2'd0, 24'h000, 32'h0);
        get_rsp(1, d, e, lat);
        asserts++;
        if (d !== shadow[0] || e !== 1'b0 || lat != 2) begin
            failures++;
            $display("FAIL read_rsp: data=%h err=%b lat=%0d, required %h/0/2", d, e, lat, shadow[0]);
        end
        asserts++;
        if (xfer_q.size() != x0 + 1 || xfer_q[x0].we !== 1'b0 || xfer_q[x0].addr !== BASE) begin
            failures++;
            $display("FAIL read_bus: count=%0d xfer=%h, required 1 read of %h", xfer_q.size() - x0, xfer_q[x0], BASE);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; int lat; int g0;
        rdy_tie = 1'b1; rsp_ready = 1'b1;
        g0 = gap_q.size();
        for (int v = 1; v <= 3; v++) begin
            send_cmd(2'd1, 24'h018, 32'(v));
            get_rsp(0, d, e, lat);
            exp_push++;
            asserts++;
            if (d !== 32'h0 || e !== 1'b0) begin
                failures++;
                $display("FAIL push_rsp: data=%h err=%b, required 0/0", d, e);
            end
            @(negedge clock);
            asserts++;
            if (cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL ready_return: cmd_ready=%b one cycle after response, required 1", cmd_ready);
            end
        end
        send_cmd(2'd0, 24'h004, 32'h0);
        get_rsp(0, d, e, lat);
        asserts++;
        if (d !== 32'(exp_push) || e !== 1'b0) begin
            failures++;
            $display("FAIL sp_read: data=%h err=%b, required %h/0", d, e, exp_push);
        end
        for (int i = g0; i < gap_q.size(); i++) begin
            asserts++;
            if (gap_q[i] < 2) begin
                failures++;
                $display("FAIL stb_gap: gap %0d is %0d cycles, required >= 2", i - g0, gap_q[i]);
            end
        end
        rdy_tie = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_run_wait();
        logic [31:0] d; logic e; int lat; int x0; int g0; int polls;
        x0 = xfer_q.size(); g0 = gap_q.size();
        send_cmd(2'd2, 24'($urandom), 32'h1);
        get_rsp(0, d, e, lat);
        asserts++;
        if (d[0] !== 1'b0 || e !== 1'b0) begin
            failures++;
            $display("FAIL run_rsp: data=%h err=%b, required bit0=0 err=0", d, e);
        end
        asserts++;
        if (xfer_q[x0] !== '{we: 1'b1, addr: BASE | 32'h00c, data: 32'h1}) begin
            failures++;
            $display("FAIL run_start: xfer=%h, required write of 1 to %h", xfer_q[x0], BASE | 32'h00c);
        end
        // core sleeps after 100 cycles; each poll round is POLL_INTERVAL + 2 cycles
        polls = xfer_q.size() - x0 - 1;
        asserts++;
        if (polls < 5 || polls > 7) begin
            failures++;
            $display("FAIL run_polls: %0d polls, required 5..7", polls);
        end
        for (int i = x0 + 1; i < xfer_q.size(); i++) begin
            asserts++;
            if (xfer_q[i].we !== 1'b0 || xfer_q[i].addr !== (BASE | 32'h00c)) begin
                failures++;
                $display("FAIL poll_xfer: xfer=%h, required read of %h", xfer_q[i], BASE | 32'h00c);
            end
        end
        for (int i = g0 + 1; i < gap_q.size(); i++) begin
            asserts++;
            if (gap_q[i] != int'(TB_POLL)) begin
                failures++;
                $display("FAIL poll_gap: gap=%0d, required %0d", gap_q[i], TB_POLL);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic e; int lat; int n;
        noack = 1'b1;
        send_cmd(2'd0, 24'h000, 32'h0);
        n = 0;
        while (n < 100) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) break;
            n++;
        end
        asserts++;
        if (n != int'(TB_TIMEOUT) || rsp_error !== 1'b1 || rsp_data !== 32'h0 || o_wb_stb !== 1'b0) begin
            failures++;
            $display("FAIL timeout_rsp: lat=%0d err=%b data=%h stb=%b, required %0d/1/0/0",
                     n, rsp_error, rsp_data, o_wb_stb, TB_TIMEOUT);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        noack = 1'b0;
        @(negedge clock);
        inject = 1'b1;
        @(negedge clock);
        inject = 1'b0;
        asserts++;
        if (last_high != int'(TB_TIMEOUT) || rsp_valid !== 1'b0 || o_wb_stb !== 1'b0) begin
            failures++;
            $display("FAIL timeout_stb: stb held %0d rsp_valid=%b stb=%b, required %0d/0/0",
                     last_high, rsp_valid, o_wb_stb, TB_TIMEOUT);
        end
        send_cmd(2'd0, 24'h000, 32'h0);
        get_rsp(0, d, e, lat);
        asserts++;
        if (d !== shadow[0] || e !== 1'b0 || lat != 2) begin
            failures++;
            $display("FAIL after_late_ack: data=%h err=%b lat=%0d, required %h/0/2", d, e, lat, shadow[0]);
        end
    endtask

    task automatic test_reserved();
        logic [31:0] d; logic e; int lat; int x0;
        x0 = xfer_q.size();
        send_cmd(2'd3, 24'($urandom), $urandom);
        get_rsp(0, d, e, lat);
        asserts++;
        if (d !== 32'h0 || e !== 1'b1 || lat != 0 || xfer_q.size() != x0) begin
            failures++;
            $display("FAIL reserved_op: data=%h err=%b lat=%0d xfers=%0d, required 0/1/0/0",
                     d, e, lat, xfer_q.size() - x0);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        noack = 1'b1;
        send_cmd(2'd1, 24'h000, $urandom);
        @(negedge clock);
        asserts++;
        if (o_wb_stb !== 1'b1) begin
            failures++;
            $display("FAIL mid_req: stb=%b, required 1", o_wb_stb);
        end
        reset = 1'b0;
        @(negedge clock);
        asserts++;
        if (o_wb_stb !== 1'b0 || o_wb_cyc !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: stb=%b cyc=%b rsp_valid=%b, required 0/0/0", o_wb_stb, o_wb_cyc, rsp_valid);
        end
        reset = 1'b1; noack = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0 || o_wb_stb !== 1'b0) bad++;
        end
        asserts++;
        if (bad != 0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: %0d cycles with rsp/stb, cmd_ready=%b, required 0/1", bad, cmd_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] d; logic e; int lat; int x0;
        logic [1:0]  op; logic [23:0] a; logic [31:0] wd; logic [31:0] exp;
        for (int i = 0; i < 24; i++) begin
            op = (i < 8) ? 2'd1 : 2'($urandom_range(0, 1));
            a  = 24'(32'h20 + 4 * ((i < 8) ? i : $urandom_range(0, 7)));
            wd = $urandom;
            x0 = xfer_q.size();
            send_cmd(op, a, wd);
            get_rsp($urandom_range(0, 3), d, e, lat);
            exp = (op == 2'd1) ? 32'h0 : shadow[a[7:2]];
            if (op == 2'd1) shadow[a[7:2]] = wd;
            asserts++;
            if (d !== exp || e !== 1'b0 || lat != 2) begin
                failures++;
                $display("FAIL rand_rsp[%0d]: data=%h err=%b lat=%0d, required %h/0/2", i, d, e, lat, exp);
            end
            asserts++;
            if (xfer_q.size() != x0 + 1 || xfer_q[x0].we !== op[0] ||
                xfer_q[x0].addr !== (BASE | {8'h00, a}) ||
                (op == 2'd1 && xfer_q[x0].data !== wd)) begin
                failures++;
                $display("FAIL rand_bus[%0d]: xfer=%h, required we=%b addr=%h data=%h",
                         i, xfer_q[x0], op[0], BASE | {8'h00, a}, wd);
            end
        end
    endtask

    task automatic test_bus_sanity();
        asserts++;
        if (cyc_bad != 0 || unstable_bad != 0) begin
            failures++;
            $display("FAIL bus_sanity: cyc!=stb %0d cycles, unstable payload %0d cycles, required 0/0",
                     cyc_bad, unstable_bad);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_run_wait();
        test_timeout();
        test_reserved();
        test_random();
        test_reset_mid();
        test_bus_sanity();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
